// File: rtl/pwm_fade_scheduler.sv
// Shares the PWM register-file write port between SPI writes and a duty-cycle fade engine.
// Latency: a granted write reaches reg_wr_* 1 cycle later; SPI is back-pressured via spi_wr_ready.
module pwm_fade_scheduler #(
    parameter logic [6:0] DUTY_ADDR = 7'h04,
    parameter int         PERIOD_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spi_wr_valid,
    input  logic [6:0]          spi_wr_addr,
    input  logic [7:0]          spi_wr_data,
    output logic                spi_wr_ready,
    input  logic                fade_start,
    input  logic [7:0]          fade_target,
    input  logic [7:0]          fade_step,
    input  logic [PERIOD_W-1:0] fade_period,
    output logic                reg_wr_en,
    output logic [6:0]          reg_wr_addr,
    output logic [7:0]          reg_wr_data,
    output logic                fade_busy,
    output logic                fade_done,
    output logic                fade_abort
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP} state_t;

    localparam logic [PERIOD_W-1:0] PER_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic [PERIOD_W-1:0]   per_q, per_d;
    logic [7:0]            tgt_q, tgt_d;
    logic [7:0]            step_q, step_d;
    logic [7:0]            shadow_q, shadow_d;
    logic                  last_spi_q, last_spi_d;
    logic                  wr_en_q, wr_en_d;
    logic [6:0]            wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  abort_q, abort_d;

    logic                  fade_req;
    logic                  grant_spi;
    logic                  grant_fade;
    logic                  spi_duty;
    logic [8:0]            sum9;
    logic [8:0]            dif9;
    logic [7:0]            next_duty;

    // Fade wins a contended cycle only when SPI held the port last time.
    always_comb begin
        fade_req   = (state_q == S_STEP);
        grant_spi  = spi_wr_valid && (!fade_req || !last_spi_q);
        grant_fade = fade_req && !grant_spi;
        spi_duty   = grant_spi && (spi_wr_addr == DUTY_ADDR);
    end

    // 9-bit arithmetic so a large step clamps at the target instead of wrapping.
    always_comb begin
        sum9 = {1'b0, shadow_q} + {1'b0, step_q};
        dif9 = {1'b0, shadow_q} - {1'b0, step_q};
        if (tgt_q > shadow_q) begin
            next_duty = (sum9 >= {1'b0, tgt_q}) ? tgt_q : sum9[7:0];
        end else begin
            next_duty = (dif9[8] || (dif9[7:0] <= tgt_q)) ? tgt_q : dif9[7:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        per_d      = per_q;
        tgt_d      = tgt_q;
        step_d     = step_q;
        shadow_d   = shadow_q;
        last_spi_d = last_spi_q;
        wr_en_d    = grant_spi || grant_fade;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;

        if (grant_spi) begin
            last_spi_d = 1'b1;
            wr_addr_d  = spi_wr_addr;
            wr_data_d  = spi_wr_data;
        end else if (grant_fade) begin
            last_spi_d = 1'b0;
            wr_addr_d  = DUTY_ADDR;
            wr_data_d  = next_duty;
        end

        if (spi_duty) begin
            shadow_d = spi_wr_data;
        end else if (grant_fade) begin
            shadow_d = next_duty;
        end

        case (state_q)
            S_IDLE: begin
                if (fade_start && !spi_duty) begin
                    tgt_d  = fade_target;
                    step_d = (fade_step == 8'd0) ? 8'd1 : fade_step;
                    per_d  = (fade_period == '0) ? PER_ONE : fade_period;
                    if (fade_target == shadow_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = (fade_period == '0) ? PER_ONE : fade_period;
                    end
                end
            end
            S_WAIT: begin
                if (spi_duty) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q <= PER_ONE) begin
                    state_d = S_STEP;
                end else begin
                    cnt_d = cnt_q - PER_ONE;
                end
            end
            S_STEP: begin
                if (spi_duty) begin
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (grant_fade) begin
                    if (next_duty == tgt_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = per_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            per_q      <= '0;
            tgt_q      <= 8'd0;
            step_q     <= 8'd0;
            shadow_q   <= 8'd0;
            last_spi_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 7'd0;
            wr_data_q  <= 8'd0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            tgt_q      <= tgt_d;
            step_q     <= step_d;
            shadow_q   <= shadow_d;
            last_spi_q <= last_spi_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    // Ready is combinational, so it is masked to keep every output low while reset is held.
    assign spi_wr_ready = grant_spi && rst_n;
    assign reg_wr_en    = wr_en_q;
    assign reg_wr_addr  = wr_addr_q;
    assign reg_wr_data  = wr_data_q;
    assign fade_busy    = (state_q != S_IDLE);
    assign fade_done    = done_q;
    assign fade_abort   = abort_q;

endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// Directed bench for pwm_fade_scheduler: table of fade scenarios plus hand-written corner sequences.
module tb_pwm_fade_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_wr_valid;
    logic [6:0]  spi_wr_addr;
    logic [7:0]  spi_wr_data;
    logic        spi_wr_ready;
    logic        fade_start;
    logic [7:0]  fade_target;
    logic [7:0]  fade_step;
    logic [15:0] fade_period;
    logic        reg_wr_en;
    logic [6:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        fade_busy;
    logic        fade_done;
    logic        fade_abort;

    pwm_fade_scheduler #(.DUTY_ADDR(7'h04), .PERIOD_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_wr_valid(spi_wr_valid), .spi_wr_addr(spi_wr_addr),
        .spi_wr_data(spi_wr_data), .spi_wr_ready(spi_wr_ready),
        .fade_start(fade_start), .fade_target(fade_target),
        .fade_step(fade_step), .fade_period(fade_period),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .fade_busy(fade_busy), .fade_done(fade_done), .fade_abort(fade_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       sh;
        logic [7:0]       tgt;
        logic [7:0]       stp;
        logic [15:0]      per;
        int               nw;
        logic [3:0][7:0]  w;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [6:0] addr;
        logic [7:0] data;
        logic       wr;
        logic       done;
        logic       abort;
        logic       busy;
    } ev_t;

    ev_t  evq[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_wr_en || fade_done || fade_abort)
            evq.push_back('{cyc, reg_wr_addr, reg_wr_data, reg_wr_en, fade_done, fade_abort, fade_busy});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        spi_wr_valid = 1'b1;
        spi_wr_addr  = a;
        spi_wr_data  = d;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (spi_wr_ready) ok = 1'b1;
        end
        chk("spi_grant", ok, 1);
        tick();
        spi_wr_valid = 1'b0;
    endtask

    task automatic start_fade(input vec_t v, output int c0);
        fade_target = v.tgt;
        fade_step   = v.stp;
        fade_period = v.per;
        fade_start  = 1'b1;
        c0 = cyc;
        tick();
        fade_start = 1'b0;
    endtask

    task automatic check_fade(input vec_t v, input int c0, input int mark);
        int pe, nwr, ndone;
        pe = (v.per == 16'd0) ? 1 : int'(v.per);
        nwr = 0;
        ndone = 0;
        for (int i = mark; i < evq.size(); i++) begin
            if (evq[i].wr) begin
                if (nwr < 4) begin
                    chk("fade_data", evq[i].data, v.w[nwr]);
                    chk("fade_addr", evq[i].addr, 7'h04);
                    chk("fade_cycle", evq[i].cyc, c0 + pe + 2 + nwr * (pe + 1));
                    chk("done_with_last", evq[i].done, (nwr == v.nw - 1));
                end
                nwr++;
            end else if (evq[i].done) begin
                chk("done_cycle_nowrite", evq[i].cyc, c0 + 1);
            end
            if (evq[i].done) ndone++;
        end
        chk("write_count", nwr, v.nw);
        chk("done_count", ndone, 1);
        chk("busy_end", fade_busy, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int c0, mark, pe;
        pe = (v.per == 16'd0) ? 1 : int'(v.per);
        spi_write(7'h04, v.sh);
        tick();
        tick();
        mark = evq.size();
        start_fade(v, c0);
        repeat (v.nw * (pe + 1) + pe + 6) tick();
        check_fade(v, c0, mark);
    endtask

    task automatic spi_stream();
        logic ok;
        spi_wr_valid = 1'b1;
        spi_wr_addr  = 7'h00;
        for (int i = 0; i < 12; i++) begin
            spi_wr_data = 8'hA0 + 8'(i);
            ok = 1'b0;
            for (int n = 0; n < 50 && !ok; n++) begin
                @(negedge clk);
                if (spi_wr_ready) ok = 1'b1;
            end
            if (!ok) chk("stream_grant", ok, 1);
            tick();
        end
        spi_wr_valid = 1'b0;
    endtask

    initial begin
        vec_t v;
        vec_t vo;
        int   c0, dummy, mark, nspi, nf, ndone, nwr;
        logic found;

        vecs[0] = '{8'h00, 8'h10, 8'h04, 16'd3, 4, {8'h10, 8'h0C, 8'h08, 8'h04}};
        vecs[1] = '{8'hF0, 8'hFF, 8'h20, 16'd2, 1, {8'h00, 8'h00, 8'h00, 8'hFF}};
        vecs[2] = '{8'h05, 8'h00, 8'h08, 16'd1, 1, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{8'h10, 8'h12, 8'h00, 16'd0, 2, {8'h00, 8'h00, 8'h12, 8'h11}};
        vecs[4] = '{8'h20, 8'h18, 8'h03, 16'd2, 3, {8'h00, 8'h18, 8'h1A, 8'h1D}};
        vecs[5] = '{8'h33, 8'h33, 8'h05, 16'd4, 0, {8'h00, 8'h00, 8'h00, 8'h00}};

        rst_n = 1'b0;
        spi_wr_valid = 1'b0; spi_wr_addr = 7'd0; spi_wr_data = 8'd0;
        fade_start = 1'b0; fade_target = 8'd0; fade_step = 8'd0; fade_period = 16'd0;
        repeat (3) tick();
        chk("reset_outputs", {spi_wr_ready, reg_wr_en, reg_wr_addr, reg_wr_data,
                              fade_busy, fade_done, fade_abort}, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // fade_start coinciding with a granted SPI duty write is dropped; shadow takes 0x22
        tick();
        mark = evq.size();
        spi_wr_valid = 1'b1; spi_wr_addr = 7'h04; spi_wr_data = 8'h22;
        fade_target = 8'h50; fade_step = 8'h01; fade_period = 16'd1; fade_start = 1'b1;
        @(negedge clk);
        chk("drop_ready", spi_wr_ready, 1);
        tick();
        spi_wr_valid = 1'b0; fade_start = 1'b0;
        repeat (5) tick();
        chk("drop_busy", fade_busy, 0);
        ndone = 0; nwr = 0;
        for (int i = mark; i < evq.size(); i++) begin
            if (evq[i].done) ndone++;
            if (evq[i].wr) nwr++;
        end
        chk("drop_no_done", ndone, 0);
        chk("drop_one_write", nwr, 1);
        v = '{8'h00, 8'h22, 8'h01, 16'd1, 0, {8'h00, 8'h00, 8'h00, 8'h00}};
        mark = evq.size();
        start_fade(v, c0);
        repeat (6) tick();
        check_fade(v, c0, mark);

        // second fade_start while busy is ignored
        spi_write(7'h04, 8'h00);
        tick(); tick();
        v  = '{8'h00, 8'h0C, 8'h04, 16'd2, 3, {8'h00, 8'h0C, 8'h08, 8'h04}};
        vo = '{8'h00, 8'h40, 8'h01, 16'd1, 0, {8'h00, 8'h00, 8'h00, 8'h00}};
        mark = evq.size();
        start_fade(v, c0);
        repeat (3) tick();
        start_fade(vo, dummy);
        repeat (16) tick();
        check_fade(v, c0, mark);

        // continuous SPI to address 0 contending with a period-1 fade
        spi_write(7'h04, 8'h00);
        tick(); tick();
        v = '{8'h00, 8'h06, 8'h02, 16'd1, 3, {8'h00, 8'h06, 8'h04, 8'h02}};
        mark = evq.size();
        fork
            spi_stream();
            begin
                tick(); tick();
                start_fade(v, c0);
            end
        join
        repeat (10) tick();
        nspi = 0; nf = 0;
        for (int i = mark; i < evq.size(); i++) begin
            if (evq[i].wr && evq[i].addr == 7'h00) begin
                chk("stream_data", evq[i].data, 8'hA0 + 8'(nspi));
                nspi++;
            end else if (evq[i].wr && evq[i].addr == 7'h04) begin
                if (nf < 3) begin
                    chk("cont_fade_data", evq[i].data, v.w[nf]);
                    chk("cont_fade_cycle", evq[i].cyc, c0 + 3 + 2 * nf);
                    chk("cont_done", evq[i].done, (nf == 2));
                end
                found = 1'b0;
                for (int j = mark; j < evq.size(); j++)
                    if (evq[j].wr && evq[j].addr == 7'h00 && evq[j].cyc == evq[i].cyc - 1) found = 1'b1;
                chk("alternate_spi_before_fade", found, 1);
                nf++;
            end
        end
        chk("stream_count", nspi, 12);
        chk("cont_fade_count", nf, 3);

        // SPI duty write aborts an in-progress fade, then a fresh fade resumes from 0x80
        spi_write(7'h04, 8'h00);
        tick(); tick();
        v = '{8'h00, 8'hF0, 8'h10, 16'd3, 0, {8'h00, 8'h00, 8'h00, 8'h00}};
        mark = evq.size();
        start_fade(v, c0);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (evq.size() > mark) found = 1'b1;
        end
        chk("abort_first_write_seen", found, 1);
        spi_write(7'h04, 8'h80);
        repeat (30) tick();
        nwr = 0; ndone = 0;
        for (int i = mark; i < evq.size(); i++) begin
            if (evq[i].done) ndone++;
            if (evq[i].wr) begin
                if (nwr == 0) begin
                    chk("abort_w0", evq[i].data, 8'h10);
                    chk("abort_w0_flag", evq[i].abort, 0);
                end else if (nwr == 1) begin
                    chk("abort_w1", evq[i].data, 8'h80);
                    chk("abort_pulse", evq[i].abort, 1);
                    chk("abort_busy", evq[i].busy, 0);
                end
                nwr++;
            end
        end
        chk("abort_write_count", nwr, 2);
        chk("abort_no_done", ndone, 0);
        chk("abort_busy_end", fade_busy, 0);
        v = '{8'h80, 8'h84, 8'h04, 16'd2, 1, {8'h00, 8'h00, 8'h00, 8'h84}};
        mark = evq.size();
        start_fade(v, c0);
        repeat (10) tick();
        check_fade(v, c0, mark);

        // asynchronous reset in the middle of a fade
        spi_write(7'h04, 8'h00);
        tick();
        v = '{8'h00, 8'h40, 8'h01, 16'd1, 0, {8'h00, 8'h00, 8'h00, 8'h00}};
        start_fade(v, c0);
        repeat (6) tick();
        spi_wr_valid = 1'b1; spi_wr_addr = 7'h00; spi_wr_data = 8'h5A;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midfade_reset_outputs", {spi_wr_ready, reg_wr_en, reg_wr_addr, reg_wr_data,
                                      fade_busy, fade_done, fade_abort}, 0);
        spi_wr_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        mark = evq.size();
        repeat (10) tick();
        chk("post_reset_busy", fade_busy, 0);
        chk("post_reset_no_writes", evq.size() - mark, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
